hub_rx_arbiter: RTL and testbench
=================================

Name: hub_rx_arbiter

Overview:
- Shares the single hub forwarding path (ethernet_frame_parser input plus repeat bus) among NUM_PORTS receive ports.
- Grants one port per frame by round-robin and forwards its byte stream with one cycle of registered latency.
- Drives per-port carrier sense so losing MACs defer, and flags collisions.
- Enforces a maximum frame length and an inter-frame gap before the next grant.

Parameters:
NUM_PORTS, 4, number of hub ports (2..8)
MAX_FRAME_BYTES, 1522, longest frame forwarded before truncation
IFG_CYCLES, 12, idle cycles enforced after each frame
PW, $clog2(NUM_PORTS), port index width (derived, localparam)
LW, $clog2(MAX_FRAME_BYTES+1), byte counter width (derived, localparam)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
port_rx_data  in  8*NUM_PORTS  byte lanes; port i on bits [8i+7:8i]
port_rx_valid  in  NUM_PORTS  per-port byte valid, high for the whole frame
fwd_data  out  8  forwarded byte
fwd_valid  out  1  fwd_data valid
fwd_sof  out  1  high with the first forwarded byte of a frame
fwd_done  out  1  one-cycle pulse the cycle after the last byte of a normally ended frame
fwd_abort  out  1  one-cycle pulse when a frame is truncated
fwd_port  out  PW  index of the granted port, held until the next grant
carrier_sense  out  NUM_PORTS  bit i high = port i must defer
collision  out  1  a non-granted port is valid this cycle (registered)
collision_cnt  out  16  saturating collision counter

Behaviour:
- Reset (reset=0, async):
  - All outputs 0.
  - State IDLE; rr_ptr = NUM_PORTS-1, so port 0 has first priority; byte counter 0.
- States: IDLE, FWD, DISCARD, IFG.
- IDLE:
  - If any port_rx_valid is set, the winner is the first set bit searching from rr_ptr+1 upward, with wrap.
  - Next cycle: state FWD, rr_ptr = winner, fwd_port = winner, fwd_data/fwd_valid = winner's byte, fwd_sof = 1, counter = 1.
  - If no valid bits are set: stay in IDLE, fwd_valid = 0.
- FWD:
  - While the granted port is valid: fwd_data <= its byte, fwd_valid <= 1, counter++.
  - Granted port valid drops: next cycle fwd_valid = 0, fwd_done = 1, then go to IFG.
  - Granted port valid with counter == MAX_FRAME_BYTES: that byte is not forwarded. Next cycle fwd_valid = 0, fwd_abort = 1, then go to DISCARD.
- DISCARD: fwd_valid = 0; stay until the granted port valid drops, then go to IFG.
- IFG:
  - Counter reloads to 0 on entry and counts IFG_CYCLES cycles.
  - Then go to IDLE; the first possible new grant is in the cycle after the IFG ends.
  - Inputs that are valid during IFG are not forwarded.
- carrier_sense (registered):
  - In FWD/DISCARD: all bits high except the granted port's.
  - In IFG: all bits high.
  - In IDLE: all low, except the cycle a grant is taken, when the losers' bits go high along with the FWD entry.
- collision (registered): set when any non-granted port is valid in any state. A simultaneous multi-request in IDLE counts for the losers.
- collision_cnt: +1 for each cycle collision is set; saturates at 16'hFFFF, no wrap.
- fwd_data holds its last value when fwd_valid = 0.
- fwd_sof, fwd_done and fwd_abort are mutually exclusive one-cycle pulses.
- Granted port drops valid on the exact byte where the counter hits MAX_FRAME_BYTES: treated as a normal end (fwd_done), not an abort.
- Reset asserted mid-frame: output stops immediately, with no fwd_done or fwd_abort.

Decomposition:
- Shared package hub_pkg: state enum (IDLE/FWD/DISCARD/IFG), default MAX_FRAME_BYTES and IFG_CYCLES constants, and a function for the port lane slice.
- One sub-module, hub_rr_arbiter. It is combinational: inputs req[NUM_PORTS] and rr_ptr; outputs grant_idx and grant_any.
- The FSM, counters and output registers stay in the top module.

Test Plan:
- Single frame: port 2 sends 64 bytes 0x00..0x3F.
  - Required: fwd_port = 2, fwd_sof with 0x00 one cycle after the first input byte, 64 valid bytes in order, fwd_done on cycle 65.
  - Required: carrier_sense = 4'b1011 during the frame, then 12 IFG cycles with carrier_sense = 4'b1111.
- Simultaneous request: ports 0 and 3 go valid together from reset.
  - Required: port 0 is granted, collision goes high and collision_cnt counts the cycles port 3 stays valid.
  - Required: after the IFG, port 3 alone re-requests and is granted.
- Round-robin: ports 1 and 2 hold requests back-to-back.
  - Required: grants alternate 1,2,1,2 across four frames, each separated by 12 idle cycles.
- Oversize: port 1 sends 1530 bytes.
  - Required: exactly 1522 bytes forwarded, fwd_abort pulses once, no fwd_done, DISCARD until port 1 drops, then IFG.
- Boundary: port 0 sends exactly 1522 bytes.
  - Required: all forwarded and fwd_done set, no abort.
- Reset mid-frame: assert reset at byte 20 of a 64-byte frame.
  - Required: all outputs 0 immediately; after release, port 0 wins with fwd_sof on its next valid byte.
- Counter saturation: force collision for 70000 cycles.
  - Required: collision_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/hub_pkg.sv
// Shared types, default constants and lane helper for the hub receive arbiter.
package hub_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FWD     = 2'd1,
        DISCARD = 2'd2,
        IFG     = 2'd3
    } hub_state_e;

    localparam int DEFAULT_MAX_FRAME_BYTES = 32'sd1522;
    localparam int DEFAULT_IFG_CYCLES      = 32'sd12;
    localparam int MAX_PORTS               = 32'sd8;

    // Byte lane of one port, taken from a bus zero-extended to MAX_PORTS lanes.
    function automatic logic [7:0] lane_byte(input logic [8*MAX_PORTS-1:0] lanes,
                                             input logic [2:0]             idx);
        return lanes[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/hub_rr_arbiter.sv
// Combinational round-robin selector: first requesting port after rr_ptr, with wrap.
module hub_rr_arbiter
    import hub_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    localparam int PW        = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PW-1:0]        rr_ptr,
    output logic [PW-1:0]        grant_idx,
    output logic                 grant_any
);

    logic [PW-1:0] cand_s;

    // Walk from the farthest candidate to the nearest so the nearest requester wins.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        cand_s    = '0;
        for (int k = NUM_PORTS; k > 32'sd0; k--) begin
            cand_s    = PW'((int'(rr_ptr) + k) % NUM_PORTS);
            grant_idx = req[cand_s] ? cand_s : grant_idx;
            grant_any = grant_any | req[cand_s];
        end
    end

endmodule

// File: rtl/hub_rx_arbiter.sv
// Hub receive arbiter: grants one receive port per frame onto the shared forwarding
// path, drives carrier sense, enforces max frame length and inter-frame gap.
module hub_rx_arbiter
    import hub_pkg::*;
#(
    parameter  int NUM_PORTS       = 4,
    parameter  int MAX_FRAME_BYTES = DEFAULT_MAX_FRAME_BYTES,
    parameter  int IFG_CYCLES      = DEFAULT_IFG_CYCLES,
    localparam int PW              = $clog2(NUM_PORTS),
    localparam int LW              = $clog2(MAX_FRAME_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [8*NUM_PORTS-1:0] port_rx_data,
    input  logic [NUM_PORTS-1:0]   port_rx_valid,
    output logic [7:0]             fwd_data,
    output logic                   fwd_valid,
    output logic                   fwd_sof,
    output logic                   fwd_done,
    output logic                   fwd_abort,
    output logic [PW-1:0]          fwd_port,
    output logic [NUM_PORTS-1:0]   carrier_sense,
    output logic                   collision,
    output logic [15:0]            collision_cnt
);

    localparam logic [LW-1:0]        CNT_ONE  = LW'(1'b1);
    localparam logic [LW-1:0]        CNT_MAX  = LW'(MAX_FRAME_BYTES);
    localparam logic [LW-1:0]        IFG_LAST = LW'(IFG_CYCLES - 32'sd1);
    localparam logic [NUM_PORTS-1:0] PORT_ONE = NUM_PORTS'(1'b1);
    localparam logic [PW-1:0]        PTR_INIT = PW'(NUM_PORTS - 32'sd1);

    hub_state_e             state_r, state_s;
    logic [LW-1:0]          cnt_r, cnt_s;
    logic [PW-1:0]          rr_ptr_r, rr_ptr_s;
    logic [PW-1:0]          port_r, port_s;
    logic [PW-1:0]          grant_idx_s, grantee_s;
    logic                   grant_any_s;
    logic [7:0]             data_r, data_s;
    logic                   valid_r, valid_s;
    logic                   sof_r, sof_s;
    logic                   done_r, done_s;
    logic                   abort_r, abort_s;
    logic [NUM_PORTS-1:0]   cs_r, cs_s;
    logic                   coll_r, coll_s;
    logic [15:0]            coll_cnt_r, coll_cnt_s;
    logic                   own_valid_s;
    logic [7:0]             own_byte_s, win_byte_s;
    logic [8*MAX_PORTS-1:0] lanes_s;

    assign lanes_s     = (8*MAX_PORTS)'(port_rx_data);
    assign own_valid_s = port_rx_valid[port_r];
    assign own_byte_s  = lane_byte(lanes_s, 3'(port_r));
    assign win_byte_s  = lane_byte(lanes_s, 3'(grant_idx_s));

    hub_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
        .req       (port_rx_valid),
        .rr_ptr    (rr_ptr_r),
        .grant_idx (grant_idx_s),
        .grant_any (grant_any_s)
    );

    // Frame FSM: grant, forward, truncate, gap; byte and gap share one counter.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        rr_ptr_s = rr_ptr_r;
        port_s   = port_r;
        data_s   = data_r;
        valid_s  = 1'b0;
        sof_s    = 1'b0;
        done_s   = 1'b0;
        abort_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_any_s) begin
                    state_s  = FWD;
                    rr_ptr_s = grant_idx_s;
                    port_s   = grant_idx_s;
                    data_s   = win_byte_s;
                    valid_s  = 1'b1;
                    sof_s    = 1'b1;
                    cnt_s    = CNT_ONE;
                end else begin
                    cnt_s = '0;
                end
            end
            FWD: begin
                if (!own_valid_s) begin
                    state_s = IFG;
                    done_s  = 1'b1;
                    cnt_s   = '0;
                end else if (cnt_r == CNT_MAX) begin
                    state_s = DISCARD;
                    abort_s = 1'b1;
                end else begin
                    data_s  = own_byte_s;
                    valid_s = 1'b1;
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            DISCARD: begin
                if (!own_valid_s) begin
                    state_s = IFG;
                    cnt_s   = '0;
                end else begin
                    state_s = DISCARD;
                end
            end
            IFG: begin
                if (cnt_r == IFG_LAST) begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // Carrier sense reflects the state being entered, so it lines up with the data.
    always_comb begin
        case (state_s)
            FWD, DISCARD: cs_s = ~(PORT_ONE << port_s);
            IFG:          cs_s = {NUM_PORTS{1'b1}};
            IDLE:         cs_s = {NUM_PORTS{1'b0}};
            default:      cs_s = {NUM_PORTS{1'b0}};
        endcase
    end

    // Any valid port other than the current (or just-chosen) owner is a collision.
    always_comb begin
        if (state_r == IDLE) begin
            grantee_s = grant_idx_s;
        end else begin
            grantee_s = port_r;
        end
        coll_s = |(port_rx_valid & ~(PORT_ONE << grantee_s));
        if (coll_s && (coll_cnt_r != 16'hFFFF)) begin
            coll_cnt_s = coll_cnt_r + 16'd1;
        end else begin
            coll_cnt_s = coll_cnt_r;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            rr_ptr_r <= PTR_INIT;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            rr_ptr_r <= rr_ptr_s;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            port_r     <= '0;
            data_r     <= 8'h00;
            valid_r    <= 1'b0;
            sof_r      <= 1'b0;
            done_r     <= 1'b0;
            abort_r    <= 1'b0;
            cs_r       <= '0;
            coll_r     <= 1'b0;
            coll_cnt_r <= 16'h0000;
        end else begin
            port_r     <= port_s;
            data_r     <= data_s;
            valid_r    <= valid_s;
            sof_r      <= sof_s;
            done_r     <= done_s;
            abort_r    <= abort_s;
            cs_r       <= cs_s;
            coll_r     <= coll_s;
            coll_cnt_r <= coll_cnt_s;
        end
    end

    assign fwd_data      = data_r;
    assign fwd_valid     = valid_r;
    assign fwd_sof       = sof_r;
    assign fwd_done      = done_r;
    assign fwd_abort     = abort_r;
    assign fwd_port      = port_r;
    assign carrier_sense = cs_r;
    assign collision     = coll_r;
    assign collision_cnt = coll_cnt_r;

endmodule

// File: tb/tb_hub_rx_arbiter.sv
// Bench for hub_rx_arbiter: frame-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_hub_rx_arbiter;

    localparam int N    = 4;
    localparam int MAXB = 1522;
    localparam int IFG  = 12;

    logic           clk      = 1'b0;
    logic           reset    = 1'b0;
    logic [8*N-1:0] rx_data  = '0;
    logic [N-1:0]   rx_valid = '0;
    logic [7:0]     fwd_data;
    logic           fwd_valid, fwd_sof, fwd_done, fwd_abort, collision;
    logic [1:0]     fwd_port;
    logic [N-1:0]   carrier_sense;
    logic [15:0]    collision_cnt;

    hub_rx_arbiter #(.NUM_PORTS(N), .MAX_FRAME_BYTES(MAXB), .IFG_CYCLES(IFG)) dut (
        .clk           (clk),
        .reset         (reset),
        .port_rx_data  (rx_data),
        .port_rx_valid (rx_valid),
        .fwd_data      (fwd_data),
        .fwd_valid     (fwd_valid),
        .fwd_sof       (fwd_sof),
        .fwd_done      (fwd_done),
        .fwd_abort     (fwd_abort),
        .fwd_port      (fwd_port),
        .carrier_sense (carrier_sense),
        .collision     (collision),
        .collision_cnt (collision_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: who owns the path, bytes taken, gap cycles left.
    int         owner, last, nbytes, ifg_left, m_port, m_ccnt;
    logic       discarding;
    logic       m_valid, m_sof, m_done, m_abort, m_coll;
    logic [7:0] m_data;
    logic [N-1:0] m_cs;

    // Observation statistics, cleared per scenario.
    int cyc = 0;
    int n_bytes, n_done, n_abort, n_cs_frame, n_cs_all;
    int sof_port_q[$], sof_data_q[$], sof_cyc_q[$], done_cyc_q[$], byte_q[$];

    function automatic logic vbit(input logic [N-1:0] v, input int i);
        logic [N-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    function automatic logic [N-1:0] onehot(input int p);
        return N'(1) << p;
    endfunction

    function automatic logic [7:0] lane(input int p);
        return 8'(rx_data >> (8*p));
    endfunction

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    endtask

    task automatic set_lane(input int p, input logic [7:0] val);
        logic [8*N-1:0] m;
        m = (8*N)'(8'hFF) << (8*p);
        rx_data = (rx_data & ~m) | ((8*N)'(val) << (8*p));
    endtask

    task automatic clear_stats();
        n_bytes = 0; n_done = 0; n_abort = 0; n_cs_frame = 0; n_cs_all = 0;
        sof_port_q.delete(); sof_data_q.delete(); sof_cyc_q.delete();
        done_cyc_q.delete(); byte_q.delete();
    endtask

    task automatic m_reset();
        owner = -1; last = N - 1; nbytes = 0; ifg_left = 0; m_port = 0; m_ccnt = 0;
        discarding = 1'b0;
        m_valid = 1'b0; m_sof = 1'b0; m_done = 1'b0; m_abort = 1'b0; m_coll = 1'b0;
        m_data = 8'h00; m_cs = '0;
    endtask

    task automatic m_step();
        logic [N-1:0] v;
        int w, g, idx;
        v = rx_valid;
        m_sof = 1'b0; m_done = 1'b0; m_abort = 1'b0; m_valid = 1'b0;
        w = -1;
        if (owner < 0 && ifg_left == 0) begin
            for (int k = 1; k <= N; k++) begin
                idx = (last + k) % N;
                if (w < 0 && vbit(v, idx)) w = idx;
            end
        end
        g = (w >= 0) ? w : m_port;
        m_coll = 1'b0;
        for (int i = 0; i < N; i++) if (i != g && vbit(v, i)) m_coll = 1'b1;
        if (m_coll && m_ccnt < 65535) m_ccnt++;
        if (ifg_left > 0) begin
            ifg_left--;
            m_cs = (ifg_left > 0) ? {N{1'b1}} : {N{1'b0}};
        end else if (owner < 0) begin
            if (w >= 0) begin
                owner = w; last = w; m_port = w; nbytes = 1; discarding = 1'b0;
                m_valid = 1'b1; m_sof = 1'b1; m_data = lane(w);
                m_cs = ~onehot(w);
            end else begin
                m_cs = {N{1'b0}};
            end
        end else if (!vbit(v, owner)) begin
            m_done = !discarding;
            owner = -1; ifg_left = IFG; m_cs = {N{1'b1}};
        end else if (discarding) begin
            m_valid = 1'b0;
        end else if (nbytes < MAXB) begin
            nbytes++; m_valid = 1'b1; m_data = lane(owner);
        end else begin
            m_abort = 1'b1; discarding = 1'b1;
        end
    endtask

    // Model advances on every clock edge and on asynchronous reset.
    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) m_reset();
            else m_step();
        end
    end

    // Compare and statistics, sampled on the falling edge.
    initial begin
        logic [34:0] act, exp;
        clear_stats();
        forever begin
            @(negedge clk);
            cyc++;
            act = {fwd_valid, fwd_sof, fwd_done, fwd_abort, fwd_port, carrier_sense,
                   collision, collision_cnt, fwd_data};
            exp = {m_valid, m_sof, m_done, m_abort, 2'(m_port), m_cs,
                   m_coll, 16'(m_ccnt), m_data};
            n_checks++;
            if (act === exp) n_pass++;
            else $display("FAIL cycle_cmp t=%0t actual=%h required=%h", $time, act, exp);
            if (fwd_valid) begin n_bytes++; byte_q.push_back(int'(fwd_data)); end
            if (fwd_sof) begin
                sof_port_q.push_back(int'(fwd_port));
                sof_data_q.push_back(int'(fwd_data));
                sof_cyc_q.push_back(cyc);
            end
            if (fwd_done) begin n_done++; done_cyc_q.push_back(cyc); end
            if (fwd_abort) n_abort++;
            if (carrier_sense == 4'b1011) n_cs_frame++;
            if (carrier_sense == 4'b1111) n_cs_all++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ticks(3);
        reset = 1'b1;
        tick();
    endtask

    initial begin
        int bad;
        // Reset state
        ticks(3);
        chk("rst_valid", fwd_valid, 0);
        chk("rst_cs", carrier_sense, 0);
        chk("rst_ccnt", collision_cnt, 0);
        chk("rst_port", fwd_port, 0);
        reset = 1'b1;
        ticks(2);

        // Single 64-byte frame on port 2
        clear_stats();
        for (int i = 0; i < 64; i++) begin
            rx_valid = 4'b0100; set_lane(2, 8'(i)); tick();
        end
        rx_valid = 4'b0000;
        ticks(16);
        chk("t1_sof_n", sof_port_q.size(), 1);
        chk("t1_port", qat(sof_port_q, 0), 2);
        chk("t1_first_byte", qat(sof_data_q, 0), 0);
        chk("t1_bytes", n_bytes, 64);
        bad = 0;
        for (int i = 0; i < byte_q.size(); i++) if (byte_q[i] != i) bad++;
        chk("t1_order", bad, 0);
        chk("t1_done_n", n_done, 1);
        chk("t1_done_lat", qat(done_cyc_q, 0) - qat(sof_cyc_q, 0), 64);
        chk("t1_cs_frame", n_cs_frame, 64);
        chk("t1_cs_ifg", n_cs_all, 12);

        // Simultaneous request from reset: ports 0 and 3
        do_reset();
        clear_stats();
        for (int c = 0; c < 50; c++) begin
            rx_valid = {(c < 20) || (c >= 35 && c < 43), 2'b00, c < 10};
            set_lane(0, 8'(c)); set_lane(3, 8'(8'h80 + 8'(c)));
            tick();
        end
        rx_valid = 4'b0000;
        ticks(16);
        chk("t2_sof_n", sof_port_q.size(), 2);
        chk("t2_first_port", qat(sof_port_q, 0), 0);
        chk("t2_second_port", qat(sof_port_q, 1), 3);
        chk("t2_ccnt", collision_cnt, 20);

        // Round-robin between ports 1 and 2, 16-byte frames
        clear_stats();
        for (int c = 0; c < 118; c++) begin
            int k, ph, own;
            k = c / 29; ph = c % 29; own = (k % 2 == 0) ? 1 : 2;
            if (k > 3 || (k == 3 && ph >= 16)) rx_valid = 4'b0000;
            else begin
                rx_valid = 4'b0110;
                if (ph >= 16 && ph < 20) rx_valid = rx_valid & ~onehot(own);
            end
            set_lane(1, 8'(c)); set_lane(2, 8'(8'h40 + 8'(c)));
            tick();
        end
        ticks(16);
        for (int i = 0; i < 4; i++) chk("t3_rr_port", qat(sof_port_q, i), (i % 2 == 0) ? 1 : 2);
        for (int i = 1; i < 4; i++) chk("t3_rr_gap", qat(sof_cyc_q, i) - qat(sof_cyc_q, i - 1), 29);

        // Oversize frame on port 1
        clear_stats();
        for (int i = 0; i < 1530; i++) begin
            rx_valid = 4'b0010; set_lane(1, 8'(i)); tick();
        end
        rx_valid = 4'b0000;
        ticks(16);
        chk("t4_bytes", n_bytes, 1522);
        chk("t4_abort_n", n_abort, 1);
        chk("t4_done_n", n_done, 0);

        // Exactly max-length frame on port 0
        clear_stats();
        for (int i = 0; i < 1522; i++) begin
            rx_valid = 4'b0001; set_lane(0, 8'(i)); tick();
        end
        rx_valid = 4'b0000;
        ticks(16);
        chk("t5_bytes", n_bytes, 1522);
        chk("t5_done_n", n_done, 1);
        chk("t5_abort_n", n_abort, 0);

        // Reset in the middle of a 64-byte frame on port 0
        for (int i = 0; i < 64; i++) begin
            rx_valid = 4'b0001; set_lane(0, 8'(i));
            if (i == 20) begin
                #2;
                reset = 1'b0;
                #1;
                chk("t6_rst_outputs", {fwd_valid, fwd_sof, fwd_done, fwd_abort, fwd_port,
                                       carrier_sense, collision, collision_cnt, fwd_data}, 0);
                clear_stats();
            end
            if (i == 22) reset = 1'b1;
            tick();
        end
        rx_valid = 4'b0000;
        ticks(16);
        chk("t6_sof_n", sof_port_q.size(), 1);
        chk("t6_port", qat(sof_port_q, 0), 0);
        chk("t6_first_byte", qat(sof_data_q, 0), 22);
        chk("t6_done_n", n_done, 1);
        chk("t6_abort_n", n_abort, 0);

        // Collision counter saturation
        rx_valid = 4'b0011;
        ticks(70000);
        chk("t7_ccnt_sat", collision_cnt, 16'hFFFF);
        rx_valid = 4'b0000;
        ticks(16);
        chk("t7_ccnt_hold", collision_cnt, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
